// File: rtl/qr_matrix_sequencer_if.sv
// Serial operand and result stream between the QR sequencer and its producer/consumer.
// The master drives operand words in and accepts result words out; the sequencer is the slave.
interface qr_matrix_sequencer_if #(
   parameter int unsigned DW = 64
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last
   );
endinterface

// File: rtl/qr_matrix_sequencer.sv
// Loads X then Y serially, holds them for an external 4x4 Q32.32 multiplier, streams Z back.
// Optional QR_SEQ_CHAIN_EN adds a chain input that feeds Z back into X for the next product.
module qr_matrix_sequencer #(
   parameter int unsigned DW     = 64,
   parameter int unsigned SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef QR_SEQ_CHAIN_EN
   input  logic             chain,
`endif
   qr_matrix_sequencer_if.slave bus,
   output logic [16*DW-1:0] x_flat,
   output logic [16*DW-1:0] y_flat,
   input  logic [16*DW-1:0] z_flat,
   output logic             busy
);

   localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {StLoadX, StLoadY, StCalc, StDrain} state_e;

   state_e        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] x_q [16];
   logic [DW-1:0] y_q [16];
   logic [DW-1:0] z_q [16];

   logic x_we, y_we, z_we, x_from_z;
   logic in_fire, out_fire, last_idx, chain_sel;

`ifdef QR_SEQ_CHAIN_EN
   assign chain_sel = chain;
`else
   assign chain_sel = 1'b0;
`endif

   // All handshake outputs decode from registered state only.
   assign bus.in_ready  = (state_q == StLoadX) || (state_q == StLoadY);
   assign bus.out_valid = (state_q == StDrain);
   assign bus.out_last  = (state_q == StDrain) && last_idx;
   assign bus.out_data  = z_q[idx_q];
   assign busy          = (state_q == StCalc) || (state_q == StDrain);

   assign last_idx = (idx_q == 4'd15);
   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      x_we     = 1'b0;
      y_we     = 1'b0;
      z_we     = 1'b0;
      x_from_z = 1'b0;
      unique case (state_q)
         StLoadX: begin
            if (in_fire) begin
               x_we  = 1'b1;
               idx_d = last_idx ? 4'd0 : idx_q + 4'd1;
               if (last_idx) state_d = StLoadY;
            end
         end
         StLoadY: begin
            if (in_fire) begin
               y_we  = 1'b1;
               idx_d = last_idx ? 4'd0 : idx_q + 4'd1;
               if (last_idx) begin
                  state_d = StCalc;
                  cnt_d   = '0;
               end
            end
         end
         StCalc: begin
            if (cnt_q == CntW'(SETTLE - 1)) begin
               z_we    = 1'b1;
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDrain: begin
            if (out_fire) begin
               idx_d = last_idx ? 4'd0 : idx_q + 4'd1;
               if (last_idx) begin
                  // Chained product reuses Z as the next left operand.
                  if (chain_sel) begin
                     x_from_z = 1'b1;
                     state_d  = StLoadY;
                  end else begin
                     state_d = StLoadX;
                  end
               end
            end
         end
         default: state_d = StLoadX;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLoadX;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            z_q[i] <= '0;
         end
      end else begin
         if (x_we) x_q[idx_q] <= bus.in_data;
         if (y_we) y_q[idx_q] <= bus.in_data;
         if (x_from_z) begin
            for (int i = 0; i < 16; i++) x_q[i] <= z_q[i];
         end
         if (z_we) begin
            for (int i = 0; i < 16; i++) z_q[i] <= z_flat[DW*i +: DW];
         end
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_flat
      assign x_flat[DW*i +: DW] = x_q[i];
      assign y_flat[DW*i +: DW] = y_q[i];
   end

endmodule

// File: tb/tb_qr_matrix_sequencer.sv
// Directed bench for qr_matrix_sequencer with a behavioural Q32.32 4x4 multiplier on z_flat.
// Build with +define+QR_SEQ_CHAIN_EN to also exercise the chain feature.
module tb_qr_matrix_sequencer;
   localparam int unsigned DW = 64;

   localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
   localparam logic [63:0] TWO   = 64'h0000_0002_0000_0000;
   localparam logic [63:0] NEG15 = 64'hFFFF_FFFE_8000_0000;
   localparam logic [63:0] NEG3  = 64'hFFFF_FFFD_0000_0000;
   localparam logic [63:0] THREE = 64'h0000_0003_0000_0000;
   localparam logic [63:0] SIX   = 64'h0000_0006_0000_0000;

   typedef logic [63:0] mat_t [16];

   logic              clk = 1'b0;
   logic              rst_n;
   logic              chain;
   logic [16*DW-1:0]  x_flat, y_flat, z_flat;
   logic              busy;
   int                chk_cnt = 0;
   int                pass_cnt = 0;

   qr_matrix_sequencer_if #(.DW(DW)) bus ();

   qr_matrix_sequencer #(.DW(DW), .SETTLE(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
`ifdef QR_SEQ_CHAIN_EN
      .chain  (chain),
`endif
      .bus    (bus.slave),
      .x_flat (x_flat),
      .y_flat (y_flat),
      .z_flat (z_flat),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [16*DW-1:0] matmul(input logic [16*DW-1:0] a,
                                               input logic [16*DW-1:0] b);
      logic [16*DW-1:0]    z;
      logic signed [127:0] acc, pa, pb, sh;
      z = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) begin
               pa  = $signed(a[DW*(4*r+k) +: DW]);
               pb  = $signed(b[DW*(4*k+c) +: DW]);
               acc = acc + pa * pb;
            end
            sh = acc >>> 32;
            z[DW*(4*r+c) +: DW] = sh[63:0];
         end
      end
      return z;
   endfunction

   assign z_flat = matmul(x_flat, y_flat);

   function automatic logic [16*DW-1:0] pack(input mat_t m);
      logic [16*DW-1:0] f;
      for (int i = 0; i < 16; i++) f[DW*i +: DW] = m[i];
      return f;
   endfunction

   task automatic make_diag(input logic [63:0] v, output mat_t m);
      for (int i = 0; i < 16; i++) m[i] = (i % 5 == 0) ? v : 64'h0;
   endtask

   // B(r,c) = 4r+c (0-based) in Q32.32; scale multiplies each entry.
   task automatic make_b(input int scale, output mat_t m);
      for (int i = 0; i < 16; i++) m[i] = {32'(i * scale), 32'h0};
   endtask

   task automatic load_matrix(input mat_t m, input bit gaps);
      int n;
      int g;
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            g = int'($urandom_range(0, 2));
            repeat (g) begin
               @(negedge clk);
               bus.in_valid = 1'b0;
            end
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = m[i];
         n = 0;
         while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) begin
            chk_cnt++;
            $display("FAIL load_timeout word=%0d in_ready=%b required=1", i, bus.in_ready);
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic collect(input bit toggle, output mat_t d, output logic [15:0] last,
                          output int got, output int stab_err);
      logic        held;
      logic [63:0] prev_d;
      int          cycles;
      held = 1'b0; prev_d = '0; cycles = 0; got = 0; stab_err = 0; last = '0;
      for (int i = 0; i < 16; i++) d[i] = '0;
      while (got < 16 && cycles < 600) begin
         @(negedge clk);
         cycles++;
         if (held && (bus.out_data !== prev_d || bus.out_valid !== 1'b1)) stab_err++;
         bus.out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               d[got]    = bus.out_data;
               last[got] = bus.out_last;
               got++;
               held = 1'b0;
            end else begin
               held   = 1'b1;
               prev_d = bus.out_data;
            end
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic check_stream(input string name, input mat_t d, input mat_t exp,
                               input logic [15:0] last, input int got);
      chk_cnt++;
      if (got !== 16) $display("FAIL %s_count got=%0d required=16", name, got);
      else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         chk_cnt++;
         if (d[i] !== exp[i])
            $display("FAIL %s_word%0d got=%h required=%h", name, i, d[i], exp[i]);
         else pass_cnt++;
      end
      chk_cnt++;
      if (last !== 16'h8000) $display("FAIL %s_last got=%h required=8000", name, last);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; chain = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b required=0", bus.out_valid);
      else pass_cnt++;
      chk_cnt++;
      if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got=%b required=0", bus.out_last);
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", busy);
      else pass_cnt++;
      chk_cnt++;
      if (x_flat !== '0 || y_flat !== '0) $display("FAIL reset_xy_flat got=nonzero required=0");
      else pass_cnt++;
   endtask

   task automatic test_identity();
      mat_t xi, b, d;
      logic [15:0] last;
      int got, se;
      make_diag(ONE, xi);
      make_b(1, b);
      load_matrix(xi, 1'b0);
      load_matrix(b, 1'b0);
      collect(1'b0, d, last, got, se);
      check_stream("identity", d, b, last, got);
      chk_cnt++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL identity_return in_ready=%b busy=%b required=1,0", bus.in_ready, busy);
      else pass_cnt++;
   endtask

   task automatic test_scaling();
      mat_t x2, yn, exp, d;
      logic [15:0] last;
      int got, se;
      make_diag(TWO, x2);
      make_diag(NEG15, yn);
      make_diag(NEG3, exp);
      load_matrix(x2, 1'b0);
      load_matrix(yn, 1'b0);
      collect(1'b0, d, last, got, se);
      check_stream("scaling", d, exp, last, got);
   endtask

   task automatic test_latency();
      mat_t x2, b, exp;
      make_diag(TWO, x2);
      make_b(1, b);
      make_b(2, exp);
      bus.out_ready = 1'b1;
      load_matrix(x2, 1'b0);
      load_matrix(b, 1'b0);
      // Returned just after edge k (Y44 accept).
      @(negedge clk);
      chk_cnt++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0)
         $display("FAIL lat_k0 out_valid=%b busy=%b in_ready=%b required=0,1,0",
                  bus.out_valid, busy, bus.in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (x_flat !== pack(x2)) $display("FAIL lat_x_stable got=%h required=%h", x_flat, pack(x2));
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL lat_k1 out_valid=%b required=0", bus.out_valid);
      else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i] || bus.out_last !== (i == 15))
            $display("FAIL lat_word%0d valid=%b data=%h last=%b required=1,%h,%b",
                     i, bus.out_valid, bus.out_data, bus.out_last, exp[i], (i == 15));
         else pass_cnt++;
      end
      @(negedge clk);
      chk_cnt++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL lat_end out_valid=%b in_ready=%b required=0,1", bus.out_valid, bus.in_ready);
      else pass_cnt++;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      mat_t xi, b, d;
      logic [15:0] last;
      int got, se;
      make_diag(ONE, xi);
      make_b(1, b);
      load_matrix(xi, 1'b1);
      load_matrix(b, 1'b1);
      collect(1'b1, d, last, got, se);
      check_stream("backpressure", d, b, last, got);
      chk_cnt++;
      if (se !== 0) $display("FAIL bp_stable errors=%0d required=0", se);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_drain();
      mat_t x2, yn, xi, b, d;
      logic [15:0] last;
      int got, se, n;
      make_diag(TWO, x2);
      make_diag(NEG15, yn);
      make_diag(ONE, xi);
      make_b(1, b);
      load_matrix(x2, 1'b0);
      load_matrix(yn, 1'b0);
      bus.out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++;
      if (n >= 20) $display("FAIL rst_mid_wait out_valid=%b required=1", bus.out_valid);
      else pass_cnt++;
      repeat (5) @(negedge clk);
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL rst_mid_async out_valid=%b busy=%b required=0,0", bus.out_valid, busy);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (bus.in_ready !== 1'b1 || x_flat !== '0)
         $display("FAIL rst_mid_release in_ready=%b x_zero=%b required=1,1",
                  bus.in_ready, (x_flat == '0));
      else pass_cnt++;
      load_matrix(xi, 1'b0);
      load_matrix(b, 1'b0);
      collect(1'b0, d, last, got, se);
      check_stream("rst_reload", d, b, last, got);
   endtask

`ifdef QR_SEQ_CHAIN_EN
   task automatic test_chain();
      mat_t x2, yi, y3, d, exp;
      logic [15:0] last;
      int got, se;
      make_diag(TWO, x2);
      make_diag(ONE, yi);
      make_diag(THREE, y3);
      make_diag(SIX, exp);
      load_matrix(x2, 1'b0);
      load_matrix(yi, 1'b0);
      chain = 1'b1;
      collect(1'b0, d, last, got, se);
      chain = 1'b0;
      check_stream("chain_first", d, x2, last, got);
      load_matrix(y3, 1'b0);
      collect(1'b0, d, last, got, se);
      check_stream("chain_second", d, exp, last, got);
   endtask
`endif

   initial begin
      test_reset();
      test_identity();
      test_scaling();
      test_latency();
      test_backpressure();
      test_reset_mid_drain();
`ifdef QR_SEQ_CHAIN_EN
      test_chain();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
